// File: rtl/rr_arbiter_encoder_4_2_pkg.sv
// Shared constants for the 4-channel round-robin arbiter/encoder.
// Holds the channel count, the index width and the FSM state encodings.
package rr_arbiter_encoder_4_2_pkg;

    localparam int NUM_CH = 4;
    localparam int IDX_W  = 2;

    typedef logic [0:0] state_t;

    localparam state_t ST_IDLE  = 1'b0;
    localparam state_t ST_GRANT = 1'b1;

endpackage

// File: rtl/rr_arbiter_encoder_4_2_pick.sv
// Combinational channel picker: scans from Last_Grant+1 upward with wrap.
// With RR_ARBITER_FIXED_PRIORITY_EN defined, channel 0 always wins and last_i is ignored.
module rr_pick_4
    import rr_arbiter_encoder_4_2_pkg::*;
(
    input  logic [NUM_CH-1:0] req_i,
    input  logic [IDX_W-1:0]  last_i,
    output logic [IDX_W-1:0]  pick_o,
    output logic              any_o
);

    logic [IDX_W-1:0] idx;
    logic             found;

    assign any_o = |req_i;

`ifdef RR_ARBITER_FIXED_PRIORITY_EN
    logic unused_last;
    assign unused_last = ^last_i;

    always_comb begin
        pick_o = '0;
        idx    = '0;
        found  = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                pick_o = IDX_W'(i);
            end
        end
    end
`else
    always_comb begin
        pick_o = '0;
        idx    = '0;
        found  = 1'b0;
        // The 2-bit add wraps naturally, so k=NUM_CH lands back on last_i itself.
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = last_i + IDX_W'(k);
            if (!found && req_i[idx]) begin
                pick_o = idx;
                found  = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/rr_arbiter_encoder_4_2.sv
// 4-channel arbiter: registered 2-bit grant index + valid, 1-cycle request-to-grant, no preemption.
// Grants end on Release_In, grantee request drop, or hold limit (Timeout_Out); RR_ARBITER_FIXED_PRIORITY_EN selects fixed priority.
module rr_arbiter_encoder_4_2
    import rr_arbiter_encoder_4_2_pkg::*;
#(
    parameter int MAX_HOLD_CYCLES = 16,
    parameter int HOLD_CNT_W      = $clog2(MAX_HOLD_CYCLES)
) (
    input  logic             Clock_In,
    input  logic             Reset_In,
    input  logic             Request_0_In,
    input  logic             Request_1_In,
    input  logic             Request_2_In,
    input  logic             Request_3_In,
    input  logic             Release_In,
    output logic [IDX_W-1:0] Encoded_Value_Out,
    output logic             Valid_Out,
    output logic             Timeout_Out
);

    localparam logic [HOLD_CNT_W-1:0] HOLD_MAX = HOLD_CNT_W'(MAX_HOLD_CYCLES - 1);

    logic [NUM_CH-1:0]     req;
    logic [IDX_W-1:0]      pick;
    logic                  any_req;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      enc_q, enc_d;
    logic                  vld_q, vld_d;
    logic                  tmo_q, tmo_d;
    logic [IDX_W-1:0]      last_q, last_d;
    logic [HOLD_CNT_W-1:0] cnt_q, cnt_d;
    logic                  rel_a, rel_b, rel_c;

    assign req = {Request_3_In, Request_2_In, Request_1_In, Request_0_In};

    rr_pick_4 u_pick (
        .req_i  (req),
        .last_i (last_q),
        .pick_o (pick),
        .any_o  (any_req)
    );

    always_comb begin
        state_d = state_q;
        enc_d   = enc_q;
        vld_d   = vld_q;
        tmo_d   = 1'b0;
        last_d  = last_q;
        cnt_d   = cnt_q;
        rel_a   = 1'b0;
        rel_b   = 1'b0;
        rel_c   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                vld_d = 1'b0;
                if (any_req) begin
                    enc_d   = pick;
                    vld_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                rel_a = Release_In;
                rel_b = ~req[enc_q];
                rel_c = (cnt_q == HOLD_MAX);
                if (rel_a || rel_b || rel_c) begin
                    vld_d   = 1'b0;
                    last_d  = enc_q;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                    // Timeout is flagged only when the hold limit alone forced the release.
                    tmo_d   = rel_c && !rel_a && !rel_b;
                end else if (cnt_q != HOLD_MAX) begin
                    cnt_d = cnt_q + HOLD_CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                vld_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clock_In) begin
        if (Reset_In) begin
            state_q <= ST_IDLE;
            enc_q   <= '0;
            vld_q   <= 1'b0;
            tmo_q   <= 1'b0;
            last_q  <= IDX_W'(NUM_CH - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            enc_q   <= enc_d;
            vld_q   <= vld_d;
            tmo_q   <= tmo_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign Encoded_Value_Out = enc_q;
    assign Valid_Out         = vld_q;
    assign Timeout_Out       = tmo_q;

endmodule

// File: tb/tb_rr_arbiter_encoder_4_2.sv
// Self-checking bench for rr_arbiter_encoder_4_2 with MAX_HOLD_CYCLES=16.
// Expected outputs for each driven cycle are queued and compared one edge later.
module tb_rr_arbiter_encoder_4_2;

`ifdef RR_ARBITER_FIXED_PRIORITY_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic       Clock_In = 1'b0;
    logic       Reset_In = 1'b1;
    logic [3:0] req = 4'b0000;
    logic       Release_In = 1'b0;
    logic [1:0] Encoded_Value_Out;
    logic       Valid_Out;
    logic       Timeout_Out;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       rel;
        logic       vld;
        logic [1:0] enc;
        logic       tmo;
    } vec_t;

    typedef struct {
        logic       vld;
        logic [1:0] enc;
        logic       tmo;
        string      tag;
    } exp_t;

    exp_t sb[$];

    always #5 Clock_In = ~Clock_In;

    rr_arbiter_encoder_4_2 #(.MAX_HOLD_CYCLES(16)) dut (
        .Clock_In          (Clock_In),
        .Reset_In          (Reset_In),
        .Request_0_In      (req[0]),
        .Request_1_In      (req[1]),
        .Request_2_In      (req[2]),
        .Request_3_In      (req[3]),
        .Release_In        (Release_In),
        .Encoded_Value_Out (Encoded_Value_Out),
        .Valid_Out         (Valid_Out),
        .Timeout_Out       (Timeout_Out)
    );

    function automatic logic [1:0] rr(input logic [1:0] n);
        return FIXED ? 2'd0 : n;
    endfunction

    task automatic check_out();
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty: output seen with no expectation queued");
        end else begin
            e = sb.pop_front();
            if (Valid_Out !== e.vld || Encoded_Value_Out !== e.enc || Timeout_Out !== e.tmo) begin
                failures++;
                $display("FAIL %s: got vld=%0b enc=%0d tmo=%0b, expected vld=%0b enc=%0d tmo=%0b",
                         e.tag, Valid_Out, Encoded_Value_Out, Timeout_Out, e.vld, e.enc, e.tmo);
            end
        end
    endtask

    task automatic step(input logic rst, input logic [3:0] r, input logic rel,
                        input logic vld, input logic [1:0] enc, input logic tmo, input string tag);
        exp_t e;
        @(negedge Clock_In);
        Reset_In   = rst;
        req        = r;
        Release_In = rel;
        e.vld = vld;
        e.enc = enc;
        e.tmo = tmo;
        e.tag = tag;
        sb.push_back(e);
        @(posedge Clock_In);
        #1;
        check_out();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[13];
        tbl[0]  = '{1'b1, 4'h0, 1'b0, 1'b0, 2'd0,    1'b0};
        tbl[1]  = '{1'b0, 4'hF, 1'b0, 1'b1, 2'd0,    1'b0};
        tbl[2]  = '{1'b0, 4'hF, 1'b1, 1'b0, 2'd0,    1'b0};
        tbl[3]  = '{1'b0, 4'hF, 1'b0, 1'b1, rr(2'd1), 1'b0};
        tbl[4]  = '{1'b0, 4'hF, 1'b1, 1'b0, rr(2'd1), 1'b0};
        tbl[5]  = '{1'b0, 4'hF, 1'b0, 1'b1, rr(2'd2), 1'b0};
        tbl[6]  = '{1'b0, 4'hF, 1'b1, 1'b0, rr(2'd2), 1'b0};
        tbl[7]  = '{1'b0, 4'hF, 1'b0, 1'b1, rr(2'd3), 1'b0};
        tbl[8]  = '{1'b0, 4'hF, 1'b1, 1'b0, rr(2'd3), 1'b0};
        tbl[9]  = '{1'b0, 4'hF, 1'b0, 1'b1, 2'd0,    1'b0};
        tbl[10] = '{1'b0, 4'hF, 1'b1, 1'b0, 2'd0,    1'b0};
        tbl[11] = '{1'b0, 4'h0, 1'b1, 1'b0, 2'd0,    1'b0};
        tbl[12] = '{1'b0, 4'h0, 1'b0, 1'b0, 2'd0,    1'b0};

        for (int i = 0; i < 13; i++) begin
            step(tbl[i].rst, tbl[i].req, tbl[i].rel, tbl[i].vld, tbl[i].enc, tbl[i].tmo,
                 $sformatf("rr_table[%0d]", i));
        end

        // Lone request on channel 2 straight after reset, then drop it.
        step(1'b1, 4'h0, 1'b0, 1'b0, 2'd0, 1'b0, "req2_reset");
        step(1'b0, 4'h4, 1'b0, 1'b1, 2'd2, 1'b0, "req2_grant");
        step(1'b0, 4'h4, 1'b0, 1'b1, 2'd2, 1'b0, "req2_hold");
        step(1'b0, 4'h0, 1'b0, 1'b0, 2'd2, 1'b0, "req2_drop");
        step(1'b0, 4'h0, 1'b0, 1'b0, 2'd2, 1'b0, "req2_enc_retained");

        // Channel 1 held with no release: 16 valid cycles, timeout pulse, re-grant.
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 4'h2, 1'b0, 1'b1, 2'd1, 1'b0, $sformatf("hold_cycle[%0d]", i));
        end
        step(1'b0, 4'h2, 1'b0, 1'b0, 2'd1, 1'b1, "hold_timeout_pulse");
        step(1'b0, 4'h2, 1'b0, 1'b1, 2'd1, 1'b0, "hold_regrant");

        // Release coinciding with the final hold cycle suppresses the timeout flag.
        for (int i = 1; i < 16; i++) begin
            step(1'b0, 4'h2, 1'b0, 1'b1, 2'd1, 1'b0, $sformatf("rel_hold[%0d]", i));
        end
        step(1'b0, 4'h2, 1'b1, 1'b0, 2'd1, 1'b0, "rel_at_limit_no_timeout");
        step(1'b0, 4'h0, 1'b0, 1'b0, 2'd1, 1'b0, "rel_at_limit_after");

        // Reset in the middle of a channel 3 grant.
        step(1'b0, 4'h8, 1'b0, 1'b1, 2'd3, 1'b0, "ch3_grant");
        step(1'b0, 4'h8, 1'b0, 1'b1, 2'd3, 1'b0, "ch3_hold");
        step(1'b1, 4'h8, 1'b0, 1'b0, 2'd0, 1'b0, "ch3_mid_reset");
        step(1'b0, 4'h9, 1'b0, 1'b1, 2'd0, 1'b0, "post_reset_ch0_first");
        step(1'b0, 4'h9, 1'b1, 1'b0, 2'd0, 1'b0, "post_reset_release");
        step(1'b0, 4'h9, 1'b0, 1'b1, rr(2'd3), 1'b0, "post_reset_next");

        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_leftover: %0d expectations never compared", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_encoder_4_2.md
Name: rr_arbiter_encoder_4_2

Overview:
- 4-channel round-robin arbiter that produces a registered 2-bit grant index plus a valid flag.
- Sits directly upstream of the 2-4 decoder. Encoded_Value_Out drives the decoder's encoded input, and Valid_Out gates the decoder's reset/enable (decoder held in reset while Valid_Out=0), yielding one-hot grants.
- Owns fairness, grant hold and timeout.

Parameters:
- MAX_HOLD_CYCLES, default 16: maximum cycles a grant may be held before forced release. Legal range 2..65536.
- HOLD_CNT_W, default $clog2(MAX_HOLD_CYCLES): hold counter width. Derived; do not override.

Ports:
- Clock_In  input  1  system clock, rising edge
- Reset_In  input  1  synchronous, active-high reset
- Request_0_In  input  1  channel 0 request (level)
- Request_1_In  input  1  channel 1 request
- Request_2_In  input  1  channel 2 request
- Request_3_In  input  1  channel 3 request
- Release_In  input  1  current grantee finished; single-cycle pulse
- Encoded_Value_Out  output  2  index of granted channel
- Valid_Out  output  1  grant active; Encoded_Value_Out meaningful
- Timeout_Out  output  1  one-cycle pulse when a grant is force-released by the hold limit

Behaviour:
- Single clock domain. Reset is synchronous and active-high; reset dominates all other inputs.
- Reset values:
  - state = IDLE
  - Encoded_Value_Out = 2'b00
  - Valid_Out = 0
  - Timeout_Out = 0
  - Last_Grant = 2'b11, so channel 0 has first priority after reset
  - hold counter = 0
- FSM has two states, IDLE and GRANT.
- IDLE:
  - If any request is high, pick the first requesting channel scanning (Last_Grant+1) mod 4 upward, with wrap 3->0.
  - On the next edge: Encoded_Value_Out = pick, Valid_Out = 1, counter = 0, go to GRANT.
  - Request-to-Valid latency is exactly 1 cycle.
  - With no request, stay in IDLE; outputs keep their values, Valid_Out = 0.
- GRANT:
  - Encoded_Value_Out is stable; other requests are ignored (no preemption).
  - The counter increments each cycle.
  - Release condition, evaluated each cycle, any of:
    - (a) Release_In = 1
    - (b) Request_<grantee>_In = 0
    - (c) counter == MAX_HOLD_CYCLES-1
  - On release, at the next edge: Valid_Out = 0, Last_Grant = grantee, state = IDLE, counter = 0.
  - Encoded_Value_Out retains its last value while Valid_Out = 0.
- Dead cycle: there is at least one cycle with Valid_Out = 0 between consecutive grants, even for the same channel. Back-to-back grant period is therefore at least 2 cycles.
- Timeout_Out is 1 for the cycle after release only when (c) is true and both (a) and (b) are false. Otherwise it is 0.
- Release_In while in IDLE is ignored.
- A request dropping during IDLE before being granted is not remembered, since requests are levels.
- Reset asserted mid-grant: outputs return to reset values at the next edge, and Last_Grant returns to 3.
- The counter saturates and never wraps; the timeout guarantees exit from GRANT.

Optional Feature:
- Macro: RR_ARBITER_FIXED_PRIORITY_EN.
- Defined: fixed priority, channel 0 highest and 3 lowest. Last_Grant is not used for selection. The hold limit and timeout are unchanged.
- Undefined: round-robin as specified above.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, GRANT)
  - NUM_CH = 4
  - IDX_W = 2
- One combinational sub-module, rr_pick_4:
  - inputs: 4-bit request vector, 2-bit Last_Grant
  - outputs: 2-bit pick, any-request flag
  - holds the rotate-and-scan logic and the fixed-priority variant under the macro.
- FSM, counter and output registers live in the top module.

Test Plan:
- Reset, then requests = 4'b1111 held, Release_In pulsed each grant: grants cycle 0,1,2,3,0, with Valid_Out low 1 cycle between grants.
- Only Request_2_In high from reset: Encoded_Value_Out = 2 and Valid_Out = 1 exactly 1 cycle later. Drop Request_2_In: Valid_Out = 0 next cycle, Timeout_Out = 0.
- Request_1_In held, no Release_In, MAX_HOLD_CYCLES = 16: Valid_Out high for 16 cycles, then low. Timeout_Out pulses once, then channel 1 is re-granted after 1 dead cycle.
- Release_In asserted on the same cycle the counter hits 15: release occurs, Timeout_Out stays 0.
- Reset asserted mid-grant of channel 3: next edge Valid_Out = 0, Encoded_Value_Out = 0. Then requests 4'b1001 give a grant to channel 0 first.
- With RR_ARBITER_FIXED_PRIORITY_EN defined, requests 4'b1111 and repeated releases: every grant = 0.
